// File: rtl/matrix_stream_port.sv
// matrix_stream_port: valid/ready streaming front-end for the 3x3 multiplier.
// Optional build macro MATSTREAM_OVERLAP_EN lets frame N+1's A load during DRAIN.
module matrix_stream_port #(
    parameter int ELEM_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ELEM_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [9*ELEM_W-1:0] mat_a,
    output logic [9*ELEM_W-1:0] mat_b,
    input  logic [9*ELEM_W-1:0] mat_res,
    output logic [ELEM_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    localparam int BUS_W = 9 * ELEM_W;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         in_cnt_q, in_cnt_d;
    logic [3:0]         out_cnt_q, out_cnt_d;
    logic [BUS_W-1:0]   mat_a_q, mat_a_d;
    logic [BUS_W-1:0]   mat_b_q, mat_b_d;
    logic [BUS_W-1:0]   shift_q, shift_d;

    logic               in_rdy;
    logic               accept;
    logic               out_hs;
    logic [3:0]         in_cnt_inc;

    // Output decode: everything comes from registered state and counters only.
    always_comb begin
        in_rdy = 1'b0;
        unique case (state_q)
            LOAD_A:  in_rdy = 1'b1;
            LOAD_B:  in_rdy = 1'b1;
            CALC:    in_rdy = 1'b0;
`ifdef MATSTREAM_OVERLAP_EN
            DRAIN:   in_rdy = (in_cnt_q < 4'd9);
`else
            DRAIN:   in_rdy = 1'b0;
`endif
            default: in_rdy = 1'b0;
        endcase
    end

    assign in_ready   = in_rdy;
    assign accept     = in_valid & in_rdy;
    assign out_valid  = (state_q == DRAIN);
    assign out_last   = (state_q == DRAIN) && (out_cnt_q == 4'd8);
    assign out_hs     = out_valid & out_ready;
    assign out_data   = shift_q[BUS_W-1 -: ELEM_W];
    assign busy       = !((state_q == LOAD_A) && (in_cnt_q == 4'd0));
    assign mat_a      = mat_a_q;
    assign mat_b      = mat_b_q;
    assign in_cnt_inc = in_cnt_q + 4'd1;

    // Next-state: element placement, FSM sequencing and result shifting.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        shift_d   = shift_q;

        unique case (state_q)
            LOAD_A: begin
                if (accept) begin
                    for (int n = 0; n < 9; n++) begin
                        if (in_cnt_q == 4'(n)) begin
                            mat_a_d[(8-n)*ELEM_W +: ELEM_W] = in_data;
                        end
                    end
                    if (in_cnt_q == 4'd8) begin
                        in_cnt_d = 4'd0;
                        state_d  = LOAD_B;
                    end else begin
                        in_cnt_d = in_cnt_inc;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    for (int n = 0; n < 9; n++) begin
                        if (in_cnt_q == 4'(n)) begin
                            mat_b_d[(8-n)*ELEM_W +: ELEM_W] = in_data;
                        end
                    end
                    if (in_cnt_q == 4'd8) begin
                        in_cnt_d = 4'd0;
                        state_d  = CALC;
                    end else begin
                        in_cnt_d = in_cnt_inc;
                    end
                end
            end
            CALC: begin
                shift_d   = mat_res;
                out_cnt_d = 4'd0;
                state_d   = DRAIN;
            end
            DRAIN: begin
`ifdef MATSTREAM_OVERLAP_EN
                // Product is already captured, so mat_a may be refilled here.
                if (accept) begin
                    for (int n = 0; n < 9; n++) begin
                        if (in_cnt_q == 4'(n)) begin
                            mat_a_d[(8-n)*ELEM_W +: ELEM_W] = in_data;
                        end
                    end
                    in_cnt_d = in_cnt_inc;
                end
`endif
                if (out_hs) begin
                    shift_d   = shift_q << ELEM_W;
                    out_cnt_d = out_cnt_q + 4'd1;
                    if (out_cnt_q == 4'd8) begin
                        out_cnt_d = 4'd0;
                        state_d   = LOAD_A;
`ifdef MATSTREAM_OVERLAP_EN
                        if (in_cnt_d == 4'd9) begin
                            in_cnt_d = 4'd0;
                            state_d  = LOAD_B;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOAD_A;
            in_cnt_q  <= 4'd0;
            out_cnt_q <= 4'd0;
            mat_a_q   <= '0;
            mat_b_q   <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            mat_a_q   <= mat_a_d;
            mat_b_q   <= mat_b_d;
            shift_q   <= shift_d;
        end
    end

endmodule
